tone_rom_player: RTL and testbench
==================================

// Module: tone_rom_player
// PURPOSE
//  Reader side of the single-period waveform ROMs (213-entry, 8-bit, 1-cycle registered q).
//  Generates ROM addresses at a fixed sample rate and plays a requested number of periods.
//  Emits one DAC sample per step, with a valid strobe. Start/stop/done control for the tune sequencer.
//  Sits between the tune sequencer and the 8-bit DAC output pins; one instance per ROM.
// PARAMETERS
//  ROM_DEPTH  213   entries per waveform period; addresses 0..ROM_DEPTH-1
//  ADDR_W     9     ROM address width
//  DATA_W     8     sample width, unsigned offset-binary
//  STEP_DIV   200   clocks per sample (25 MHz / 200 / 213 = 587 Hz); must be >= 2
//  MIDSCALE   8'h80 idle DAC level
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       1-cycle request; honoured only in IDLE
//  stop       in   1       1-cycle abort; honoured in PLAY/DRAIN
//  dur        in   16      periods to play; sampled with start; 0 = play until stop
//  rom_addr   out  ADDR_W  address to ROM
//  rom_q      in   DATA_W  ROM data; valid 1 clk after rom_addr changes
//  dac_data   out  DATA_W  current sample, registered
//  dac_valid  out  1       1-cycle pulse when dac_data is updated with a new sample
//  busy       out  1       high in PLAY and DRAIN
//  done       out  1       1-cycle pulse on return to IDLE from PLAY/DRAIN
//  vol        in   2       attenuation shift (present only with TONE_VOLUME_EN)
// BEHAVIOUR
//  Reset (async, rst_n low): state IDLE, rom_addr 0, dac_data MIDSCALE, dac_valid 0, busy 0,
//   done 0, divider 0, period count 0. Reset mid-play aborts immediately; no done pulse.
//  FSM states: IDLE, PLAY, DRAIN.
//  IDLE: rom_addr held at 0; dac_data = MIDSCALE. start -> latch dur, clear divider and period count.
//   Enter PLAY next cycle. stop in IDLE is ignored.
//  PLAY: divider counts 0..STEP_DIV-1 and then wraps. On the terminal count (tick):
//   - dac_data <= rom_q (sample of current rom_addr); dac_valid pulses that cycle.
//   - rom_addr <= rom_addr+1, or 0 if rom_addr == ROM_DEPTH-1 (wrap); wrap increments period count.
//   - If dur != 0 and the wrap makes period count == dur, go to DRAIN (rom_addr = 0).
//  First dac_valid occurs STEP_DIV clocks after PLAY entry and carries ROM[0].
//  STEP_DIV >= 2 guarantees rom_q is settled for the held address at each tick.
//  DRAIN: holds the last sample for STEP_DIV clocks without dac_valid.
//   Then: IDLE, dac_data <= MIDSCALE, done pulse.
//  stop in PLAY/DRAIN: next cycle IDLE, dac_data MIDSCALE, rom_addr 0, done pulse. No dac_valid that
//   cycle even if a tick coincides. stop has priority over tick.
//  start while busy: ignored (dur not re-latched). start and stop in the same cycle in IDLE: start wins.
//  Period counter is 16 bits; with dur=0 it wraps freely and is not compared.
//  busy is 1 from the cycle after start is accepted through the cycle before done.
// CONFIGURATION
//  TONE_VOLUME_EN defined: vol port exists.
//   s = rom_q - MIDSCALE (signed 9b); dac_data = MIDSCALE + (s >>> vol), truncated to DATA_W.
//   vol is sampled at each tick.
//  TONE_VOLUME_EN undefined: no vol port; dac_data = rom_q unmodified.
// TESTING (ROM model: 213-entry sine, ROM[0]=0x80, ROM[1]=0x83, ROM[212]=0x7C; STEP_DIV=4)
//  1. Assert rst_n low mid-play -> immediately rom_addr=0, dac_data=0x80, busy=0, no done.
//  2. start, dur=1:
//     - dac_valid every 4 clks, 213 pulses, values 0x80, 0x83, ..., 0x7C.
//     - Then 4 clks of DRAIN, then done=1 for 1 clk and dac_data=0x80.
//  3. start, dur=0, stop after 50th dac_valid:
//     - next clk IDLE, done pulse, dac_data=0x80.
//     - no further dac_valid.
//  4. start, dur=3:
//     - rom_addr wraps 212->0 exactly 3 times.
//     - 639 dac_valid pulses, then done.
//  5. start again while busy (dur=5 second time) -> ignored; run ends after original dur=1.
//     start+stop same clk in IDLE -> PLAY entered.
//  6. TONE_VOLUME_EN, vol=1: rom_q 0xFF -> dac_data 0xBF; rom_q 0x00 -> 0x40.
//     vol=0 -> dac_data equals rom_q.

Source files
------------

// File: rtl/tone_rom_player_if.sv
// Sequencer/ROM/DAC bundle for tone_rom_player; the vol signal exists only with TONE_VOLUME_EN.
// master = sequencer and ROM side, slave = the player.
interface tone_rom_player_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              start;
  logic              stop;
  logic [15:0]       dur;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              busy;
  logic              done;
`ifdef TONE_VOLUME_EN
  logic [1:0]        vol;

  modport master (output start, stop, dur, rom_q, vol,
                  input  rom_addr, dac_data, dac_valid, busy, done);
  modport slave  (input  start, stop, dur, rom_q, vol,
                  output rom_addr, dac_data, dac_valid, busy, done);
`else
  modport master (output start, stop, dur, rom_q,
                  input  rom_addr, dac_data, dac_valid, busy, done);
  modport slave  (input  start, stop, dur, rom_q,
                  output rom_addr, dac_data, dac_valid, busy, done);
`endif
endinterface

// File: rtl/tone_rom_player.sv
// Steps a registered waveform ROM at one sample per STEP_DIV clocks and plays dur periods to the DAC.
// All outputs registered; no backpressure. Optional TONE_VOLUME_EN adds arithmetic-shift attenuation.
module tone_rom_player #(
  parameter int                ROM_DEPTH = 213,
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 8,
  parameter int                STEP_DIV  = 200,
  parameter logic [DATA_W-1:0] MIDSCALE  = 8'h80
) (
  input logic               clk,
  input logic               rst_n,
  tone_rom_player_if.slave  bus
);

  localparam int                DIV_W     = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dac_q;
  logic              vld_q;
  logic              done_q;
  logic              busy_q;
  logic [15:0]       dur_q;
  logic [15:0]       per_q;

  logic              tick_d;
  logic              wrap_d;
  logic [15:0]       per_d;
  logic [DATA_W-1:0] sample_d;

  always_comb begin
    tick_d = (div_q == DIV_LAST);
    wrap_d = (addr_q == ADDR_LAST);
    per_d  = per_q + 16'd1;
  end

`ifdef TONE_VOLUME_EN
  logic signed [DATA_W:0] diff_d;
  logic signed [DATA_W:0] shr_d;

  // Attenuate around midscale so the offset-binary zero level is preserved.
  always_comb begin
    diff_d   = $signed({1'b0, bus.rom_q}) - $signed({1'b0, MIDSCALE});
    shr_d    = diff_d >>> bus.vol;
    sample_d = MIDSCALE + shr_d[DATA_W-1:0];
  end
`else
  always_comb sample_d = bus.rom_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      addr_q  <= '0;
      dac_q   <= MIDSCALE;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dur_q   <= '0;
      per_q   <= '0;
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          addr_q <= '0;
          dac_q  <= MIDSCALE;
          if (bus.start) begin
            dur_q   <= bus.dur;
            div_q   <= '0;
            per_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= PLAY;
          end
        end
        PLAY: begin
          // Abort wins over a coinciding tick: no sample is emitted on the way out.
          if (bus.stop) begin
            state_q <= IDLE;
            dac_q   <= MIDSCALE;
            addr_q  <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (tick_d) begin
            div_q <= '0;
            dac_q <= sample_d;
            vld_q <= 1'b1;
            if (wrap_d) begin
              addr_q <= '0;
              per_q  <= per_d;
              if (dur_q != 16'd0 && per_d == dur_q) state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        DRAIN: begin
          if (bus.stop || tick_d) begin
            state_q <= IDLE;
            dac_q   <= MIDSCALE;
            addr_q  <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr  = addr_q;
  assign bus.dac_data  = dac_q;
  assign bus.dac_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_tone_rom_player.sv
// Bench for tone_rom_player: sine ROM model, edge-indexed timing model of each play run.
module tb_tone_rom_player;
  localparam int DEPTH = 213;
  localparam int SD    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tone_rom_player_if #(.ADDR_W(9), .DATA_W(8)) bus ();

  tone_rom_player #(
    .ROM_DEPTH(DEPTH), .ADDR_W(9), .DATA_W(8), .STEP_DIV(SD), .MIDSCALE(8'h80)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:DEPTH-1];
  always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

  int total = 0;
  int bad   = 0;
  int cur_vol = 0;

  int         v_edge[$];
  logic [7:0] v_dat[$];
  int         done_edge[$];
  int         wraps;
  int         busy_cnt;
  logic [7:0] dat_after_done;
  logic [8:0] addr_after_done;
  logic       busy_after_done;
  logic       timeout;

  // Expected sample k of a run: ROM walked cyclically, attenuated around 0x80.
  function automatic logic [7:0] exp_sample(int k);
    int v, s;
    v = int'(rom[k % DEPTH]);
    s = v - 128;
    s = s >>> cur_vol;
    return 8'((128 + s) & 255);
  endfunction

  // Edge (counted from the edge that accepts start = 1) at which done is seen.
  function automatic int exp_done(int d, int s);
    int dn;
    dn = (d > 0) ? SD * DEPTH * d + SD + 1 : 32'h3fffffff;
    if (s >= 2 && s < dn) dn = s;
    return dn;
  endfunction

  function automatic int exp_nvalid(int d, int s);
    int dn, n;
    dn = exp_done(d, s);
    n  = (dn <= SD + 1) ? 0 : (dn - (SD + 1) + SD - 1) / SD;
    if (d > 0 && n > DEPTH * d) n = DEPTH * d;
    return n;
  endfunction

  // Drives one start (edge 1), optional stop at edge stop_e, optional second start at restart_e.
  task automatic run(input logic [15:0] d, input int stop_e, input int restart_e, input int max_e);
    logic [8:0] prev_addr;
    int post;
    v_edge.delete(); v_dat.delete(); done_edge.delete();
    wraps = 0; busy_cnt = 0; timeout = 1'b1; post = -1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dur = d; bus.stop = (stop_e == 1);
    prev_addr = bus.rom_addr;
    for (int e = 1; e <= max_e; e++) begin
      @(posedge clk); #1;
      if (bus.dac_valid) begin v_edge.push_back(e); v_dat.push_back(bus.dac_data); end
      if (bus.done) begin
        done_edge.push_back(e);
        if (post < 0) begin
          post = e;
          dat_after_done  = bus.dac_data;
          addr_after_done = bus.rom_addr;
          busy_after_done = bus.busy;
        end
      end
      if (bus.busy) busy_cnt++;
      if (prev_addr == 9'd212 && bus.rom_addr == 9'd0) wraps++;
      prev_addr = bus.rom_addr;
      bus.start = (e + 1 == restart_e);
      bus.dur   = bus.start ? 16'd5 : 16'($urandom);
      bus.stop  = (e + 1 == stop_e);
      if (post >= 0 && e >= post + 3 * SD) begin timeout = 1'b0; break; end
    end
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    repeat (2) @(posedge clk); #1;
    total++; if (bus.rom_addr !== 9'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus.rom_addr); end
    total++; if (bus.dac_data !== 8'h80) begin bad++; $display("FAIL reset_dac: got %02h want 80", bus.dac_data); end
    total++; if ({bus.dac_valid, bus.busy, bus.done} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {bus.dac_valid, bus.busy, bus.done}); end
    rst_n = 1'b1;
    @(posedge clk); #1; bus.start = 1'b1; bus.dur = 16'd0;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (41) @(posedge clk);
    #3;
    total++; if (bus.busy !== 1'b1 || bus.rom_addr === 9'd0) begin bad++; $display("FAIL pre_reset_play: busy=%b addr=%0d want busy=1 addr!=0", bus.busy, bus.rom_addr); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.rom_addr !== 9'd0) begin bad++; $display("FAIL midplay_reset_addr: got %0d want 0", bus.rom_addr); end
    total++; if (bus.dac_data !== 8'h80) begin bad++; $display("FAIL midplay_reset_dac: got %02h want 80", bus.dac_data); end
    total++; if ({bus.busy, bus.done, bus.dac_valid} !== 3'b000) begin bad++; $display("FAIL midplay_reset_flags: got %b want 000", {bus.busy, bus.done, bus.dac_valid}); end
    repeat (2) @(posedge clk); #1; rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.dac_valid || bus.busy) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_dur1();
    run(16'd1, -1, -1, exp_done(1, -1) + 40);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL dur1_timeout: got no done want done"); end
    total++; if (v_dat.size() != DEPTH) begin bad++; $display("FAIL dur1_count: got %0d want %0d", v_dat.size(), DEPTH); end
    total++; if (v_dat.size() < DEPTH || v_dat[0] !== 8'h80 || v_dat[1] !== 8'h83 || v_dat[DEPTH-1] !== 8'h7C) begin
      bad++; $display("FAIL dur1_ends: got first/second/last wrong want 80/83/7C");
    end
    for (int k = 0; k < v_dat.size(); k++) begin
      total++;
      if (v_dat[k] !== exp_sample(k) || v_edge[k] != SD * k + SD + 1) begin
        bad++; if (bad < 20) $display("FAIL dur1_sample[%0d]: got %02h@%0d want %02h@%0d", k, v_dat[k], v_edge[k], exp_sample(k), SD * k + SD + 1);
      end
    end
    total++; if (done_edge.size() != 1 || done_edge[0] != exp_done(1, -1)) begin bad++; $display("FAIL dur1_done: got %0d pulses want 1 at edge %0d", done_edge.size(), exp_done(1, -1)); end
    total++; if (dat_after_done !== 8'h80 || busy_after_done !== 1'b0) begin bad++; $display("FAIL dur1_idle: got dac=%02h busy=%b want 80/0", dat_after_done, busy_after_done); end
    total++; if (busy_cnt != exp_done(1, -1) - 1) begin bad++; $display("FAIL dur1_busy: got %0d want %0d", busy_cnt, exp_done(1, -1) - 1); end
    total++; if (wraps != 1) begin bad++; $display("FAIL dur1_wraps: got %0d want 1", wraps); end
  endtask

  task automatic test_stop();
    int s;
    s = SD * 49 + SD + 2;  // edge just after the 50th sample
    run(16'd0, s, -1, s + 40);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL stop_timeout: got no done want done"); end
    total++; if (v_dat.size() != 50) begin bad++; $display("FAIL stop_count: got %0d want 50", v_dat.size()); end
    total++; if (done_edge.size() != 1 || done_edge[0] != s) begin bad++; $display("FAIL stop_done: got %0d pulses want 1 at edge %0d", done_edge.size(), s); end
    total++; if (dat_after_done !== 8'h80 || addr_after_done !== 9'd0) begin bad++; $display("FAIL stop_idle: got dac=%02h addr=%0d want 80/0", dat_after_done, addr_after_done); end
  endtask

  task automatic test_dur3();
    run(16'd3, -1, -1, exp_done(3, -1) + 40);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL dur3_timeout: got no done want done"); end
    total++; if (wraps != 3) begin bad++; $display("FAIL dur3_wraps: got %0d want 3", wraps); end
    total++; if (v_dat.size() != 3 * DEPTH) begin bad++; $display("FAIL dur3_count: got %0d want %0d", v_dat.size(), 3 * DEPTH); end
    for (int k = 0; k < v_dat.size(); k++) begin
      total++;
      if (v_dat[k] !== exp_sample(k) || v_edge[k] != SD * k + SD + 1) begin
        bad++; if (bad < 20) $display("FAIL dur3_sample[%0d]: got %02h@%0d want %02h@%0d", k, v_dat[k], v_edge[k], exp_sample(k), SD * k + SD + 1);
      end
    end
    total++; if (done_edge.size() != 1 || done_edge[0] != exp_done(3, -1)) begin bad++; $display("FAIL dur3_done: got %0d pulses want 1 at edge %0d", done_edge.size(), exp_done(3, -1)); end
  endtask

  task automatic test_start_while_busy();
    run(16'd1, -1, 100, exp_done(1, -1) + 40);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL restart_timeout: got no done want done"); end
    total++; if (v_dat.size() != DEPTH) begin bad++; $display("FAIL restart_count: got %0d want %0d", v_dat.size(), DEPTH); end
    total++; if (done_edge.size() != 1 || done_edge[0] != exp_done(1, -1)) begin bad++; $display("FAIL restart_done: got %0d pulses want 1 at edge %0d", done_edge.size(), exp_done(1, -1)); end
  endtask

  task automatic test_start_stop_same();
    run(16'd1, 1, -1, exp_done(1, -1) + 40);
    total++; if (v_dat.size() != DEPTH) begin bad++; $display("FAIL startstop_count: got %0d want %0d", v_dat.size(), DEPTH); end
    total++; if (done_edge.size() != 1 || done_edge[0] != exp_done(1, -1)) begin bad++; $display("FAIL startstop_done: got %0d pulses want 1 at edge %0d", done_edge.size(), exp_done(1, -1)); end
  endtask

  task automatic test_random();
    int d, s, r, en;
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 2);
      if (d == 0) s = $urandom_range(2, 400);
      else s = ($urandom_range(0, 1) == 1) ? $urandom_range(2, SD * DEPTH * d + SD + 1) : -1;
      r = $urandom_range(2, 300);
      en = exp_done(d, s);
      run(16'(d), s, r, en + 40);
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rand%0d_timeout: got no done want done at %0d", it, en); end
      total++; if (v_dat.size() != exp_nvalid(d, s)) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d (d=%0d s=%0d)", it, v_dat.size(), exp_nvalid(d, s), d, s); end
      for (int k = 0; k < v_dat.size(); k++) begin
        total++;
        if (v_dat[k] !== exp_sample(k) || v_edge[k] != SD * k + SD + 1) begin
          bad++; if (bad < 20) $display("FAIL rand%0d_sample[%0d]: got %02h@%0d want %02h@%0d", it, k, v_dat[k], v_edge[k], exp_sample(k), SD * k + SD + 1);
        end
      end
      total++; if (done_edge.size() != 1 || done_edge[0] != en) begin bad++; $display("FAIL rand%0d_done: got %0d pulses want 1 at edge %0d", it, done_edge.size(), en); end
      total++; if (busy_cnt != en - 1 || dat_after_done !== 8'h80) begin bad++; $display("FAIL rand%0d_busy: got busy=%0d dac=%02h want %0d/80", it, busy_cnt, dat_after_done, en - 1); end
    end
  endtask

`ifdef TONE_VOLUME_EN
  task automatic test_volume();
    int s;
    s = SD * 3 + SD + 2;
    rom[0] = 8'hFF; rom[1] = 8'h00;
    for (int v = 1; v >= 0; v--) begin
      cur_vol = v; bus.vol = 2'(v);
      run(16'd0, s, -1, s + 40);
      total++; if (v_dat.size() != 4) begin bad++; $display("FAIL vol%0d_count: got %0d want 4", v, v_dat.size()); end
      for (int k = 0; k < v_dat.size(); k++) begin
        total++; if (v_dat[k] !== exp_sample(k)) begin bad++; $display("FAIL vol%0d_sample[%0d]: got %02h want %02h", v, k, v_dat[k], exp_sample(k)); end
      end
    end
    rom[0] = 8'h80; rom[1] = 8'h83;
    cur_vol = 2; bus.vol = 2'd2;
    run(16'd1, -1, -1, exp_done(1, -1) + 40);
    for (int k = 0; k < v_dat.size(); k++) begin
      total++; if (v_dat[k] !== exp_sample(k)) begin bad++; if (bad < 20) $display("FAIL vol2_sample[%0d]: got %02h want %02h", k, v_dat[k], exp_sample(k)); end
    end
    cur_vol = 0; bus.vol = 2'd0;
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++)
      rom[i] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * i / 213.0)));
    rom[0] = 8'h80; rom[1] = 8'h83; rom[DEPTH-1] = 8'h7C;
    bus.start = 1'b0; bus.stop = 1'b0; bus.dur = 16'd0;
`ifdef TONE_VOLUME_EN
    bus.vol = 2'd0;
`endif
    test_reset();
    test_dur1();
    test_stop();
    test_dur3();
    test_start_while_busy();
    test_start_stop_same();
`ifdef TONE_VOLUME_EN
    test_volume();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
